pmp_iter_checker: RTL and testbench

//  Multi-cycle physical memory protection checker that scales to large entry counts
//  (NrPMPEntries/NrSPMPEntries up to 64) without a single-cycle 64-way compare.

---
 rtl/pmp_iter_checker.sv | 171 +++++++++++++++++
 tb/tb_pmp_iter_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_iter_checker.sv
// Iterative PMP checker: scans ENTRIES_PER_CYCLE entries per clock, lowest index first, stops at first hit.
// Latency: k+1 cycles from accept to resp_valid_o (k = 1-based chunk of first hit, or number of chunks).
// Backpressure: one request in flight; req_ready_o low from accept until the response is taken.
module pmp_iter_checker #(
    parameter int NR_ENTRIES        = 64,
    parameter int ENTRIES_PER_CYCLE = 8,
    parameter int PLEN              = 56,
    parameter int PMP_LEN           = 54,
    localparam int IDX_W            = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [PLEN-1:0]               addr_i,
    input  logic [2:0]                    access_i,
    input  logic [1:0]                    priv_i,
    input  logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_i,
    input  logic [NR_ENTRIES*8-1:0]       conf_i,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic                          allow_o,
    output logic                          matched_o,
    output logic [IDX_W-1:0]              match_idx_o
);

    localparam int EPC       = ENTRIES_PER_CYCLE;
    localparam int NR_CHUNKS = (NR_ENTRIES + EPC - 1) / EPC;
    localparam int CW        = (NR_CHUNKS > 1) ? $clog2(NR_CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      chunk_q, chunk_d;
    logic [PMP_LEN-1:0] tgt_q;
    logic [2:0]         access_q;
    logic [1:0]         priv_q;
    logic               allow_q, allow_d;
    logic               matched_q, matched_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               hit;
    logic               hit_allow;
    logic [IDX_W-1:0]   hit_idx;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_i[1:0];

    function automatic logic entry_match(input logic [PMP_LEN-1:0] lo,
                                         input logic [PMP_LEN-1:0] hi,
                                         input logic [PMP_LEN-1:0] t,
                                         input logic [1:0]         mode);
        logic [PMP_LEN-1:0] care;
        // hi ^ (hi+1) sets the trailing ones plus the first zero: the NAPOT don't-care bits
        care = ~(hi ^ (hi + PMP_LEN'(1)));
        case (mode)
            2'd1:    entry_match = (lo < hi) && (t >= lo) && (t < hi);
            2'd2:    entry_match = (t == hi);
            2'd3:    entry_match = ((t ^ hi) & care) == '0;
            default: entry_match = 1'b0;
        endcase
    endfunction

    function automatic logic entry_allow(input logic [7:0] cfg,
                                         input logic [2:0] access,
                                         input logic [1:0] priv);
        logic [2:0] perm;
        perm = (cfg[1] && !cfg[0]) ? 3'b000 : cfg[2:0];
        if (priv == 2'd3 && !cfg[7])
            entry_allow = 1'b1;
        else
            entry_allow = (access != 3'b000) && ((access & ~perm) == 3'b000);
    endfunction

    // Lanes visited high to low so the lowest matching index is written last
    always_comb begin
        int                 idx;
        logic [PMP_LEN-1:0] lo;
        logic [PMP_LEN-1:0] hi;
        logic [7:0]         cfg;
        hit       = 1'b0;
        hit_allow = 1'b0;
        hit_idx   = '0;
        idx       = 0;
        lo        = '0;
        hi        = '0;
        cfg       = '0;
        for (int j = EPC - 1; j >= 0; j--) begin
            idx = int'(chunk_q) * EPC + j;
            if (idx < NR_ENTRIES) begin
                hi  = conf_addr_i[idx*PMP_LEN +: PMP_LEN];
                cfg = conf_i[idx*8 +: 8];
                lo  = '0;
                if (idx > 0)
                    lo = conf_addr_i[(idx-1)*PMP_LEN +: PMP_LEN];
                if (entry_match(lo, hi, tgt_q, cfg[4:3])) begin
                    hit       = 1'b1;
                    hit_allow = entry_allow(cfg, access_q, priv_q);
                    hit_idx   = IDX_W'(idx);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        chunk_d   = chunk_q;
        allow_d   = allow_q;
        matched_d = matched_q;
        idx_d     = idx_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = SCAN;
                    chunk_d = '0;
                end
            end
            SCAN: begin
                if (hit) begin
                    allow_d   = hit_allow;
                    matched_d = 1'b1;
                    idx_d     = hit_idx;
                    state_d   = RESP;
                end else if (chunk_q == CW'(NR_CHUNKS - 1)) begin
                    allow_d   = (priv_q == 2'd3);
                    matched_d = 1'b0;
                    idx_d     = '0;
                    state_d   = RESP;
                end else begin
                    chunk_d = chunk_q + CW'(1);
                end
            end
            RESP: begin
                if (resp_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            chunk_q   <= '0;
            tgt_q     <= '0;
            access_q  <= '0;
            priv_q    <= '0;
            allow_q   <= 1'b0;
            matched_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            chunk_q   <= chunk_d;
            allow_q   <= allow_d;
            matched_q <= matched_d;
            idx_q     <= idx_d;
            if (state_q == IDLE && req_valid_i) begin
                tgt_q    <= PMP_LEN'(addr_i[PLEN-1:2]);
                access_q <= access_i;
                priv_q   <= priv_i;
            end
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign allow_o      = allow_q;
    assign matched_o    = matched_q;
    assign match_idx_o  = idx_q;

endmodule

// File: tb/tb_pmp_iter_checker.sv
// Directed bench for pmp_iter_checker (64 entries, 8 per cycle) with an expected-result queue.
module tb_pmp_iter_checker;

    localparam int NR      = 64;
    localparam int EPC     = 8;
    localparam int PLEN    = 56;
    localparam int PMP_LEN = 54;
    localparam int IDX_W   = 6;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   req_valid;
    logic                   req_ready;
    logic [PLEN-1:0]        addr;
    logic [2:0]             access;
    logic [1:0]             priv;
    logic [NR*PMP_LEN-1:0]  conf_addr;
    logic [NR*8-1:0]        conf;
    logic                   resp_valid;
    logic                   resp_ready;
    logic                   allow;
    logic                   matched;
    logic [IDX_W-1:0]       match_idx;

    logic [PMP_LEN-1:0]     pa [NR];
    logic [7:0]             pc [NR];

    typedef struct {
        logic allow;
        logic matched;
        int   idx;
        int   lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            conf_addr[i*PMP_LEN +: PMP_LEN] = pa[i];
            conf[i*8 +: 8]                  = pc[i];
        end
    end

    pmp_iter_checker #(
        .NR_ENTRIES        (NR),
        .ENTRIES_PER_CYCLE (EPC),
        .PLEN              (PLEN),
        .PMP_LEN           (PMP_LEN)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .addr_i       (addr),
        .access_i     (access),
        .priv_i       (priv),
        .conf_addr_i  (conf_addr),
        .conf_i       (conf),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .allow_o      (allow),
        .matched_o    (matched),
        .match_idx_o  (match_idx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < NR; i++) begin
            pa[i] = '0;
            pc[i] = '0;
        end
    endtask

    // Called #1 after a rising edge; the handshake happens on the next edge
    task automatic issue(input logic [PLEN-1:0] a, input logic [2:0] acc, input logic [1:0] p,
                         input logic e_allow, input logic e_matched, input int e_idx, input int e_lat);
        exp_t e;
        e.allow   = e_allow;
        e.matched = e_matched;
        e.idx     = e_idx;
        e.lat     = e_lat;
        sb.push_back(e);
        check("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
        addr      = a;
        access    = acc;
        priv      = p;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   lat;
        lat = 1;
        check({tag, "_busy"}, {63'd0, req_ready}, 64'd0);
        while (!resp_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        e = sb.pop_front();
        check({tag, "_valid"},   {63'd0, resp_valid}, 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        check({tag, "_allow"},   {63'd0, allow},      {63'd0, e.allow});
        check({tag, "_matched"}, {63'd0, matched},    {63'd0, e.matched});
        check({tag, "_idx"},     64'(match_idx),      64'(e.idx));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"},   {63'd0, resp_valid}, 64'd1);
            check({tag, "_hold_ready"},   {63'd0, req_ready},  64'd0);
            check({tag, "_hold_allow"},   {63'd0, allow},      {63'd0, e.allow});
            check({tag, "_hold_matched"}, {63'd0, matched},    {63'd0, e.matched});
            check({tag, "_hold_idx"},     64'(match_idx),      64'(e.idx));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check({tag, "_done_valid"}, {63'd0, resp_valid}, 64'd0);
        check({tag, "_done_ready"}, {63'd0, req_ready},  64'd1);
    endtask

    initial begin
        int seen;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        addr       = '0;
        access     = '0;
        priv       = '0;
        clear_cfg();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        check("rst_req_ready",  {63'd0, req_ready},  64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_allow",      {63'd0, allow},      64'd0);
        check("rst_matched",    {63'd0, matched},    64'd0);
        check("rst_idx",        64'(match_idx),      64'd0);

        // 32 KiB NAPOT region at 0x80000000 in entry 37 (chunk 5 -> latency 6)
        pa[37] = 54'h2000_0FFF;
        pc[37] = 8'h19;
        issue(56'h8000_1000, 3'b001, 2'd0, 1'b1, 1'b1, 37, 6);
        collect("napot_read", 0);
        issue(56'h8000_1000, 3'b010, 2'd0, 1'b0, 1'b1, 37, 6);
        collect("napot_write", 0);
        issue(56'h8000_1000, 3'b011, 2'd0, 1'b0, 1'b1, 37, 6);
        collect("napot_rw", 0);
        issue(56'h8000_1000, 3'b010, 2'd3, 1'b1, 1'b1, 37, 6);
        collect("napot_m_unlocked", 0);
        pc[37] = 8'h99;
        issue(56'h8000_1000, 3'b010, 2'd3, 1'b0, 1'b1, 37, 6);
        collect("napot_m_locked", 0);
        issue(56'h8000_8000, 3'b001, 2'd0, 1'b0, 1'b0, 0, 9);
        collect("napot_outside", 0);

        clear_cfg();
        issue(56'h8000_1000, 3'b001, 2'd3, 1'b1, 1'b0, 0, 9);
        collect("off_m_read", 0);
        issue(56'h8000_1000, 3'b001, 2'd1, 1'b0, 1'b0, 0, 9);
        collect("off_s_read", 0);

        // Entry 0 TOR [0,0x400) RX overlaps entry 1 NA4 0x100 (W-only reserved)
        pa[0] = 54'h400;
        pc[0] = 8'h0D;
        pa[1] = 54'h100;
        pc[1] = 8'h12;
        issue(56'h400, 3'b100, 2'd0, 1'b1, 1'b1, 0, 2);
        collect("tor_lowest_wins", 0);
        issue(56'hFFC, 3'b001, 2'd0, 1'b1, 1'b1, 0, 2);
        collect("tor_top_word", 0);
        issue(56'h1000, 3'b001, 2'd0, 1'b0, 1'b0, 0, 9);
        collect("tor_upper_excl", 0);
        pc[0] = 8'h00;
        issue(56'h400, 3'b010, 2'd0, 1'b0, 1'b1, 1, 2);
        collect("na4_reserved_w", 0);

        clear_cfg();
        pa[1] = 54'h500;
        pa[2] = 54'h400;
        pc[2] = 8'h09;
        issue(56'h1140, 3'b001, 2'd0, 1'b0, 1'b0, 0, 9);
        collect("tor_inverted", 0);

        clear_cfg();
        pa[37] = 54'h2000_0FFF;
        pc[37] = 8'h19;
        issue(56'h8000_1000, 3'b001, 2'd0, 1'b1, 1'b1, 37, 6);
        collect("backpressure", 4);

        // Reset during SCAN must abort without a response
        clear_cfg();
        addr      = 56'h8000_1000;
        access    = 3'b001;
        priv      = 2'd3;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ready",  {63'd0, req_ready},  64'd1);
        check("abort_valid",  {63'd0, resp_valid}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (resp_valid)
                seen++;
        end
        check("abort_no_resp",   64'(seen),          64'd0);
        check("abort_idle_ready", {63'd0, req_ready}, 64'd1);

        issue(56'h8000_1000, 3'b001, 2'd1, 1'b0, 1'b0, 0, 9);
        collect("after_abort", 0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
